// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: opcodes, dispatch FSM states and the buffered operation record.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic [2:0]           sel;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } alu_op_t;

  function automatic logic is_div0(input alu_op_t op);
    return (op.sel == OP_DIV) && (op.b == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_fifo.sv
// ----------------------------------------------------------------------------
// alu_op_fifo: synchronous FIFO of alu_op_t with full/empty/count status.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  alu_op_t                wr_op,
  input  logic                   pop,
  output alu_op_t                rd_op,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  alu_op_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_op   = mem[rd_ptr];

  // Storage is not reset; contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_dispatch.sv
// ----------------------------------------------------------------------------
// alu_op_dispatch: buffers ALU ops and issues them one at a time to the ALU.
// Define ALU_DISPATCH_DIV0_TRAP_EN to trap DIV by zero before the ALU. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_valid,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (WIDTH != ALU_WIDTH) begin : g_width_check
    $error("alu_op_dispatch: WIDTH must equal alu_pkg::ALU_WIDTH");
  end

  disp_state_t   state;
  disp_state_t   next_state;
  alu_op_t       wr_op;
  alu_op_t       head_op;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          head_div0;
  logic          trap;

  assign in_ready = (fifo_count != CW'(DEPTH));
  assign push     = in_valid && !fifo_full;
  assign wr_op    = '{sel: in_sel, a: in_a, b: in_b};

  alu_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wr_op (wr_op),
    .pop   (pop),
    .rd_op (head_op),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef ALU_DISPATCH_DIV0_TRAP_EN
  assign head_div0 = is_div0(head_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      trap <= 1'b0;
    end else if (pop) begin
      trap <= head_div0;
    end
  end
`else
  assign head_div0 = 1'b0;
  assign trap      = 1'b0;
`endif

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    alu_valid  = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        alu_valid  = !trap;
        next_state = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A trapped divide is issued as a harmless ADD with b=1 so the ALU never sees x/0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= 3'b000;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (pop) begin
        alu_a   <= head_op.a;
        alu_b   <= head_div0 ? WIDTH'(1) : head_op.b;
        alu_sel <= head_div0 ? OP_ADD : head_op.sel;
      end
      if (state == ST_DRIVE) begin
        res_data <= trap ? {WIDTH{1'b1}} : alu_out;
        res_err  <= trap;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_dispatch.sv
// ----------------------------------------------------------------------------
// tb_alu_op_dispatch: directed and random checks of alu_op_dispatch vs a model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_dispatch;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic        alu_valid;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

`ifdef ALU_DISPATCH_DIV0_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_op_dispatch #(.DEPTH(4), .WIDTH(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_valid (alu_valid),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  // Stand-in for SixteenBit_ALU; its x/0 answer is arbitrary (0 here).
  function automatic logic [15:0] alu_fn(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return (b == 16'd0) ? 16'd0 : a / b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

  function automatic exp_t model(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (TRAP_ON && s == 3'd3 && b == 16'd0) begin
      e.data = 16'hFFFF;
      e.err  = 1'b1;
    end else begin
      e.data = alu_fn(s, a, b);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: record accepted ops, compare every consumed result in order.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(in_sel, in_a, in_b));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("stale_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(e.data));
          check("res_err", 32'(res_err), 32'(e.err));
        end
      end
      if (TRAP_ON && alu_valid) check("div0_reached_alu", 32'(alu_sel == 3'd3 && alu_b == 16'd0), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic push_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    bit hs = 1'b0;
    int n  = 0;
    in_sel   = s;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
    end
    if (!hs) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   sent;
    int   cyc;
    bit   hs;
    bit   seen;
    in_sel = '0; in_a = '0; in_b = '0;
    do_reset();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_alu_valid", 32'(alu_valid), 32'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);

    // ADD latency: handshake cycle 0, pop 1, drive 2, result 3
    res_ready = 1'b1;
    in_sel = OP_ADD; in_a = 16'd3080; in_b = 16'd756; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("add_c1_res_valid", 32'(res_valid), 32'd0);
    tick();
    check("add_c2_alu_valid", 32'(alu_valid), 32'd1);
    check("add_c2_alu_ops", {alu_a, alu_b}, {16'd3080, 16'd756});
    tick();
    check("add_c3_res_valid", 32'(res_valid), 32'd1);
    check("add_c3_res_data", 32'(res_data), 32'd3836);
    tick();
    check("add_c4_res_valid", 32'(res_valid), 32'd0);

    // Divide by zero
    e = model(OP_DIV, 16'd3080, 16'd0);
    seen = 1'b0;
    in_sel = OP_DIV; in_a = 16'd3080; in_b = 16'd0; in_valid = 1'b1;
    tick(); in_valid = 1'b0; seen |= alu_valid;
    tick(); seen |= alu_valid;
    tick(); seen |= alu_valid;
    check("div0_res_valid", 32'(res_valid), 32'd1);
    check("div0_res_data", 32'(res_data), 32'(e.data));
    check("div0_res_err", 32'(res_err), 32'(e.err));
    check("div0_alu_valid_seen", 32'(seen), TRAP_ON ? 32'd0 : 32'd1);
    tick();

    // Fill and drain
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_count", 32'(u_dut.u_fifo.count), 32'd4);
    res_ready = 1'b1;
    tick();
    check("fill_in_ready_idle", 32'(in_ready), 32'd0);
    tick();
    check("fill_in_ready_after_pop", 32'(in_ready), 32'd1);
    drain();

    // Backpressure
    res_ready = 1'b0;
    push_op(OP_XOR, 16'h2560, 16'h72E0);
    cyc = 0;
    while (!res_valid && cyc < 20) begin tick(); cyc++; end
    for (int i = 0; i < 4; i++) begin
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data", 32'(res_data), 32'h5780);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_consumed", 32'(res_valid), 32'd0);

    // Reset during DRIVE with two ops queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_op(OP_ADD, 16'($urandom), 16'($urandom));
    check("rmid_count3", 32'(u_dut.u_fifo.count), 32'd3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("rmid_drive", 32'(alu_valid), 32'd1);
    check("rmid_count2", 32'(u_dut.u_fifo.count), 32'd2);
    reset = 1'b1;
    tick();
    check("rmid_res_valid", 32'(res_valid), 32'd0);
    check("rmid_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    res_ready = 1'b1;
    repeat (10) tick();
    check("rmid_count0", 32'(u_dut.u_fifo.count), 32'd0);

    // Simultaneous push and pop at count 2
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_op(OP_SUB, 16'($urandom), 16'($urandom));
    repeat (2) tick();
    check("sim_hold", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("sim_count_pre", 32'(u_dut.u_fifo.count), 32'd2);
    in_sel = OP_OR; in_a = 16'($urandom); in_b = 16'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sim_count_post", 32'(u_dut.u_fifo.count), 32'd2);
    check("sim_drive", 32'(alu_valid), 32'd1);
    drain();

    // Random traffic against the scoreboard
    sent = 0; cyc = 0; in_valid = 1'b0;
    while ((sent < 300 || in_valid) && cyc < 10000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (!in_valid || hs) begin
        if (sent < 300 && $urandom_range(0, 2) != 0) begin
          in_sel   = 3'($urandom_range(0, 7));
          in_a     = 16'($urandom);
          in_b     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
          in_valid = 1'b1;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_all_sent", 32'(in_valid), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
